// File: rtl/c_next_seq_pkg.sv
// Shared definitions for the control-state sequencer and the C-select mux.
// Holds the sequencing-field encodings, the control-state address width,
// the restore target state and the memory-wait FSM state encoding.
package c_next_seq_pkg;

  // Control-state address width.
  localparam int ADDR_W = 6;

  // State the C-select mux forces when a restore is requested. The mux uses
  // the same constant so both sides agree on the recovery entry point.
  localparam int RESTORE_ADDR = 35;

  // Width of the memory-wait counter; holds WAIT_MAX values up to 255.
  localparam int WAIT_CNT_W = 8;

  // Microinstruction sequencing field.
  typedef enum logic [1:0] {
    SEQ_NEXT   = 2'b00,
    SEQ_JUMP   = 2'b01,
    SEQ_BRANCH = 2'b10,
    SEQ_DECODE = 2'b11
  } seq_ctrl_e;

  // Memory-wait handshake states.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_WAIT    = 2'b01,
    ST_TIMEOUT = 2'b10
  } wait_state_e;

endpackage

// File: rtl/c_wait_timer.sv
// Memory-wait handshake for the control-state sequencer.
// Tracks how long the current state has been waiting on memory, holds C
// while waiting, and requests a restore when the wait runs out.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   mem_req    current state issues a memory access
//   mem_ready  memory completes the access this cycle
//   load_c     C register should load Cin at the coming edge
//   stall      registered: C is being held for memory (WAIT state)
//   restore    registered: one-cycle restore request (TIMEOUT state)
module c_wait_timer #(
  parameter int WAIT_MAX = 8   // legal range 1..255
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  output logic load_c,
  output logic stall,
  output logic restore
);

  import c_next_seq_pkg::*;

  wait_state_e           state;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  // stall and restore are registered alongside the state so they are exact
  // decodes of WAIT and TIMEOUT without a combinational path from memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      stall    <= 1'b0;
      restore  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_CNT_W'(1);
            stall    <= 1'b1;
          end else begin
            wait_cnt <= '0;
            stall    <= 1'b0;
          end
          restore <= 1'b0;
        end
        ST_WAIT: begin
          // Ready is tested first so a completion on the last tolerated
          // cycle is accepted rather than turned into a restore.
          if (mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            stall    <= 1'b0;
            restore  <= 1'b0;
          end else if (wait_cnt == WAIT_CNT_W'(WAIT_MAX)) begin
            state    <= ST_TIMEOUT;
            wait_cnt <= '0;
            stall    <= 1'b0;
            restore  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
          end
        end
        ST_TIMEOUT: begin
          // A late mem_ready is ignored; the mux is already restoring.
          state    <= ST_RUN;
          wait_cnt <= '0;
          stall    <= 1'b0;
          restore  <= 1'b0;
        end
        default: begin
          // Illegal encoding: recover to a clean RUN.
          state    <= ST_RUN;
          wait_cnt <= '0;
          stall    <= 1'b0;
          restore  <= 1'b0;
        end
      endcase
    end
  end

  // C advances whenever the current state is not waiting on memory.
  always_comb begin
    load_c = 1'b0;
    case (state)
      ST_RUN:     load_c = !(mem_req && !mem_ready);
      ST_WAIT:    load_c = mem_ready;
      ST_TIMEOUT: load_c = 1'b1;
      default:    load_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/c_next_seq.sv
// Control-state sequencer directly upstream of the C-select mux.
// Holds the current control state C, computes the candidate next state C5
// from the sequencing field, latches the branch flag and owns the
// memory-wait handshake (via c_wait_timer).
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   Cin            state selected by the downstream mux; loaded into C
//   seq_ctrl       00=next, 01=jump, 10=branch-on-flag, 11=decode
//   jaddr          jump/branch target
//   opcode         instruction opcode for decode dispatch
//   flag_in        ALU condition flag
//   branch_update  captures flag_in into the branch flag
//   mem_req        current state issues a memory access
//   mem_ready      memory completes the access this cycle
//   C              current control state (registered)
//   C5             candidate next state to the mux
//   restore        one-cycle restore request to the mux
//   stall          C is being held for memory
//   branch_taken   branch condition true this cycle
module c_next_seq #(
  parameter int ADDR_W       = c_next_seq_pkg::ADDR_W,
  parameter int RESTORE_ADDR = c_next_seq_pkg::RESTORE_ADDR,
  parameter int WAIT_MAX     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Cin,
  input  logic [1:0]        seq_ctrl,
  input  logic [ADDR_W-1:0] jaddr,
  input  logic [3:0]        opcode,
  input  logic              flag_in,
  input  logic              branch_update,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] C,
  output logic [ADDR_W-1:0] C5,
  output logic              restore,
  output logic              stall,
  output logic              branch_taken
);

  import c_next_seq_pkg::*;

  logic              flag_q;
  logic              load_c;
  logic [ADDR_W-1:0] c_inc;

  c_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_ready (mem_ready),
    .load_c    (load_c),
    .stall     (stall),
    .restore   (restore)
  );

  // Wraps naturally modulo 2^ADDR_W.
  assign c_inc = C + ADDR_W'(1);

  // Candidate next state. While stalled the mux must see C itself so a
  // held state is re-selected instead of skipped.
  always_comb begin
    C5           = c_inc;
    branch_taken = 1'b0;
    case (seq_ctrl_e'(seq_ctrl))
      SEQ_NEXT:   C5 = c_inc;
      SEQ_JUMP:   C5 = jaddr;
      SEQ_BRANCH: begin
        branch_taken = flag_q;
        C5           = flag_q ? jaddr : c_inc;
      end
      SEQ_DECODE: C5 = ADDR_W'({opcode, 2'b00});
      default:    C5 = c_inc;
    endcase
    if (stall) C5 = C;
  end

  // State register: C takes whatever the mux selected when not held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) C <= '0;
    else if (load_c) C <= Cin;
  end

  // Branch flag captures independently of stall; branches always see the
  // value latched before the current edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flag_q <= 1'b0;
    else if (branch_update) flag_q <= flag_in;
  end

  // The mux must drive the restore entry while a restore is in flight.
  a_restore_addr : assert property (
    @(posedge clk) disable iff (reset) restore |-> (Cin == ADDR_W'(RESTORE_ADDR))
  );

endmodule

// File: tb/tb_c_next_seq.sv
module tb_c_next_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Cin;
  logic [1:0] seq_ctrl;
  logic [5:0] jaddr;
  logic [3:0] opcode;
  logic       flag_in;
  logic       branch_update;
  logic       mem_req;
  logic       mem_ready;
  logic [5:0] C;
  logic [5:0] C5;
  logic       restore;
  logic       stall;
  logic       branch_taken;

  // Mux model: loop C5 back (or the restore entry), or drive Cin directly.
  logic       mux_loop;
  logic [5:0] cin_drv;
  assign Cin = mux_loop ? (restore ? 6'd35 : C5) : cin_drv;

  c_next_seq #(
    .ADDR_W       (6),
    .RESTORE_ADDR (35),
    .WAIT_MAX     (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Cin           (Cin),
    .seq_ctrl      (seq_ctrl),
    .jaddr         (jaddr),
    .opcode        (opcode),
    .flag_in       (flag_in),
    .branch_update (branch_update),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .C             (C),
    .C5            (C5),
    .restore       (restore),
    .stall         (stall),
    .branch_taken  (branch_taken)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [5:0] c;
    logic [5:0] c5;
    logic       st;
    logic       rs;
    logic       bt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int c, input int c5,
                     input bit st, input bit rs, input bit bt);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.c    = 6'(c);
    e.c5   = 6'(c5);
    e.st   = st;
    e.rs   = rs;
    e.bt   = bt;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (e.cyc != cyc || C !== e.c || C5 !== e.c5 || stall !== e.st ||
          restore !== e.rs || branch_taken !== e.bt) begin
        n_fail++;
        $display("FAIL %s (cyc %0d): got C=%0d C5=%0d stall=%b restore=%b bt=%b, want C=%0d C5=%0d stall=%b restore=%b bt=%b",
                 e.name, cyc, C, C5, stall, restore, branch_taken,
                 e.c, e.c5, e.st, e.rs, e.bt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; seq_ctrl = 2'b00; jaddr = '0; opcode = '0;
    flag_in = 1'b0; branch_update = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    mux_loop = 1'b1; cin_drv = '0;

    step(); step();
    chk("reset", 0, 1, 0, 0, 0);
    step();
    reset = 1'b0;
    chk("post_reset", 0, 1, 0, 0, 0);

    // Sequential stepping through the whole address space.
    for (int i = 1; i < 64; i++) begin
      step();
      chk("count", i, (i + 1) % 64, 0, 0, 0);
    end
    step();
    chk("wrap", 0, 1, 0, 0, 0);

    // Jump to 5.
    step();
    seq_ctrl = 2'b01; jaddr = 6'd5;
    chk("jump", 1, 5, 0, 0, 0);
    step();
    branch_update = 1'b1; flag_in = 1'b1;
    chk("flag_cap1", 5, 5, 0, 0, 0);
    step();
    branch_update = 1'b0; seq_ctrl = 2'b10; jaddr = 6'd20;
    chk("branch_taken", 5, 20, 0, 0, 1);
    step();
    seq_ctrl = 2'b01; jaddr = 6'd5; branch_update = 1'b1; flag_in = 1'b0;
    chk("flag_cap0", 20, 5, 0, 0, 0);
    step();
    // New flag presented this cycle must not affect the current branch.
    seq_ctrl = 2'b10; jaddr = 6'd20; branch_update = 1'b1; flag_in = 1'b1;
    chk("branch_not_taken", 5, 6, 0, 0, 0);
    step();
    branch_update = 1'b0;
    chk("branch_latched", 6, 20, 0, 0, 1);

    // Decode dispatch.
    step();
    seq_ctrl = 2'b11; opcode = 4'hB;
    chk("decode_b", 20, 44, 0, 0, 0);
    step();
    opcode = 4'hF;
    chk("decode_f", 44, 60, 0, 0, 0);
    step();
    seq_ctrl = 2'b01; jaddr = 6'd10;
    chk("jump10", 60, 10, 0, 0, 0);

    // Memory wait resolved by ready after 3 stall cycles.
    step();
    seq_ctrl = 2'b00; mem_req = 1'b1; mem_ready = 1'b0;
    mux_loop = 1'b0; cin_drv = 6'd11;
    chk("wait_enter", 10, 11, 0, 0, 0);
    step();
    mem_req = 1'b0;
    chk("wait1", 10, 10, 1, 0, 0);
    step();
    chk("wait2", 10, 10, 1, 0, 0);
    step();
    mem_ready = 1'b1;
    chk("wait3", 10, 10, 1, 0, 0);
    step();
    mem_ready = 1'b0; mux_loop = 1'b1; mem_req = 1'b1;
    chk("ready_load", 11, 12, 0, 0, 0);

    // Memory timeout: 8 stall cycles then one restore cycle.
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) mem_req = 1'b0;
      chk("to_wait", 11, 11, 1, 0, 0);
    end
    step();
    mem_ready = 1'b1;
    chk("restore", 11, 12, 0, 1, 0);
    step();
    mem_ready = 1'b0;
    chk("after_restore", 35, 36, 0, 0, 0);
    step();
    mem_req = 1'b1;
    chk("run_again", 36, 37, 0, 0, 0);

    // Ready on the last tolerated wait cycle wins over timeout.
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) mem_req = 1'b0;
      if (i == 8) begin
        mem_ready = 1'b1; mux_loop = 1'b0; cin_drv = 6'd50;
      end
      chk("tie_wait", 36, 36, 1, 0, 0);
    end
    step();
    mem_ready = 1'b0; mux_loop = 1'b1; mem_req = 1'b1;
    chk("tie_ready", 50, 51, 0, 0, 0);

    // Reset asserted mid-wait.
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 1) mem_req = 1'b0;
      chk("rw_wait", 50, 50, 1, 0, 0);
    end
    step();
    #2;
    reset = 1'b1;
    chk("reset_mid_wait", 0, 1, 0, 0, 0);
    step();
    chk("reset_hold", 0, 1, 0, 0, 0);
    step();
    reset = 1'b0;
    chk("after_reset", 0, 1, 0, 0, 0);
    step();
    chk("resume", 1, 2, 0, 0, 0);

    step();
    step();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
